// File: rtl/bg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bg_pkg
// Purpose  : Shared state encoding and constants for the background sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package bg_pkg;

    typedef enum logic [1:0] {
        ST_SHOW     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_FADE_IN  = 2'd2
    } state_t;

    localparam logic [1:0] FADE_MAX = 2'd3;

    localparam logic [1:0] BG_GRASS = 2'd0;
    localparam logic [1:0] BG_UW    = 2'd1;
    localparam logic [1:0] BG_BLUE  = 2'd2;
    localparam logic [1:0] BG_GREEN = 2'd3;

    // Auto mode walks the backgrounds in index order and wraps.
    function automatic logic [1:0] next_bg(input logic [1:0] bg);
        return bg + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bg_scene_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bg_scene_sequencer_if
// Purpose  : Frame-strobe/control inputs and background outputs of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface bg_scene_sequencer_if;
    logic       frame_start;
    logic [1:0] sel_manual;
    logic       auto_en;
    logic       hold;
    logic [1:0] bg_sel;
    logic [1:0] fade_level;
    logic [9:0] anim_counter;
    logic       busy;

    modport master (
        output frame_start, sel_manual, auto_en, hold,
        input  bg_sel, fade_level, anim_counter, busy
    );

    modport slave (
        input  frame_start, sel_manual, auto_en, hold,
        output bg_sel, fade_level, anim_counter, busy
    );
endinterface
`default_nettype wire

// File: rtl/frame_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : frame_divider
// Purpose  : Counts frame ticks 0..TERM-1 with clear; flags the terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module frame_divider #(
    parameter int TERM  = 4,
    parameter int WIDTH = 10
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_tick,
    input  wire logic i_clear,
    input  wire logic i_en,
    output logic      o_tc
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(TERM - 1);

    logic [WIDTH-1:0] r_count;

    assign o_tc = (r_count == c_last);

    // Wraps to zero on the tick where the terminal count is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick && i_en) begin
            r_count <= o_tc ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bg_scene_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bg_scene_sequencer
// Purpose  : Frame-synchronous background select with dimmed cross-fades,
//            manual/auto modes and a frame animation counter.
// Revision : 1.0 - initial release
// ============================================================================
module bg_scene_sequencer
    import bg_pkg::*;
#(
    parameter int DWELL_FRAMES = 300,
    parameter int STEP_FRAMES  = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    bg_scene_sequencer_if.slave   bus
);

    state_t     r_state;
    logic [1:0] r_bg_sel;
    logic [1:0] r_fade;
    logic [9:0] r_anim;
    logic       r_busy;
    logic [1:0] r_sel_prev;
    logic [1:0] r_target;

    logic w_show_auto;
    logic w_in_fade;
    logic w_dwell_tc;
    logic w_step_tc;
    logic w_man_trig;

    assign w_show_auto = (r_state == ST_SHOW) && bus.auto_en;
    assign w_in_fade   = (r_state != ST_SHOW);
    // Debounce: the request must match the value seen on the previous frame.
    assign w_man_trig  = !bus.auto_en && (bus.sel_manual == r_sel_prev)
                         && (bus.sel_manual != r_bg_sel);

    frame_divider #(
        .TERM  (DWELL_FRAMES),
        .WIDTH (10)
    ) u_dwell (
        .clk     (clk),
        .rst     (reset),
        .i_tick  (bus.frame_start),
        .i_clear (bus.frame_start && !w_show_auto),
        .i_en    (w_show_auto),
        .o_tc    (w_dwell_tc)
    );

    frame_divider #(
        .TERM  (STEP_FRAMES),
        .WIDTH (4)
    ) u_step (
        .clk     (clk),
        .rst     (reset),
        .i_tick  (bus.frame_start),
        .i_clear (bus.frame_start && !w_in_fade),
        .i_en    (w_in_fade),
        .o_tc    (w_step_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_SHOW;
            r_bg_sel   <= BG_GRASS;
            r_fade     <= 2'd0;
            r_anim     <= 10'd0;
            r_busy     <= 1'b0;
            r_sel_prev <= 2'd0;
            r_target   <= 2'd0;
        end else if (bus.frame_start) begin
            r_sel_prev <= bus.sel_manual;
            if (!bus.hold) begin
                r_anim <= r_anim + 10'd1;
            end
            case (r_state)
                ST_SHOW: begin
                    if (w_man_trig) begin
                        r_target <= bus.sel_manual;
                        r_state  <= ST_FADE_OUT;
                        r_fade   <= 2'd0;
                        r_busy   <= 1'b1;
                    end else if (bus.auto_en && w_dwell_tc) begin
                        r_target <= next_bg(r_bg_sel);
                        r_state  <= ST_FADE_OUT;
                        r_fade   <= 2'd0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_FADE_OUT: begin
                    if (w_step_tc) begin
                        if (r_fade != FADE_MAX) begin
                            r_fade <= r_fade + 2'd1;
                        end else begin
                            // Swap only while fully dimmed.
                            r_bg_sel <= r_target;
                            r_state  <= ST_FADE_IN;
                        end
                    end
                end
                ST_FADE_IN: begin
                    if (w_step_tc) begin
                        r_fade <= r_fade - 2'd1;
                        if (r_fade == 2'd1) begin
                            r_state <= ST_SHOW;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_SHOW;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bg_sel       = r_bg_sel;
    assign bus.fade_level   = r_fade;
    assign bus.anim_counter = r_anim;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bg_scene_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bg_scene_sequencer
// Purpose  : Two sequencer instances (different dwell/step) against a
//            frame-level reference model through an expected-value queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bg_scene_sequencer;

    localparam int D0 = 3;
    localparam int S0 = 1;
    localparam int D1 = 5;
    localparam int S1 = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       fs;
    logic [1:0] sel;
    logic       auto_v;
    logic       hold_v;

    always #5 clk = ~clk;

    bg_scene_sequencer_if bus_a ();
    bg_scene_sequencer_if bus_b ();

    assign bus_a.frame_start = fs;
    assign bus_a.sel_manual  = sel;
    assign bus_a.auto_en     = auto_v;
    assign bus_a.hold        = hold_v;
    assign bus_b.frame_start = fs;
    assign bus_b.sel_manual  = sel;
    assign bus_b.auto_en     = auto_v;
    assign bus_b.hold        = hold_v;

    bg_scene_sequencer #(.DWELL_FRAMES(D0), .STEP_FRAMES(S0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    bg_scene_sequencer #(.DWELL_FRAMES(D1), .STEP_FRAMES(S1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    logic [14:0] obs [2];
    assign obs[0] = {bus_a.bg_sel, bus_a.fade_level, bus_a.anim_counter, bus_a.busy};
    assign obs[1] = {bus_b.bg_sel, bus_b.fade_level, bus_b.anim_counter, bus_b.busy};

    // Reference model: a transition is k frames old; fade and swap follow from k.
    int dw [2] = '{D0, D1};
    int st [2] = '{S0, S1};
    int m_bg [2], m_fade [2], m_anim [2], m_busy [2], m_prev [2], m_tgt [2];
    int m_k [2], m_dwell [2];
    bit m_trans [2];

    logic [14:0] q0 [$];
    logic [14:0] q1 [$];

    int total = 0;
    int bad   = 0;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_bg[i] = 0; m_fade[i] = 0; m_anim[i] = 0; m_busy[i] = 0;
            m_prev[i] = 0; m_tgt[i] = 0; m_k[i] = 0; m_dwell[i] = 0;
            m_trans[i] = 1'b0;
        end
    endfunction

    function automatic void model_start(int i, int tgt);
        m_trans[i] = 1'b1;
        m_k[i]     = 0;
        m_fade[i]  = 0;
        m_busy[i]  = 1;
        m_tgt[i]   = tgt;
    endfunction

    function automatic void model_frame(int i, int s_in, bit a_in, bit h_in);
        int s = st[i];
        if (m_trans[i]) begin
            m_k[i]++;
            if (m_k[i] < 4 * s) begin
                m_fade[i] = m_k[i] / s;
            end else begin
                if (m_k[i] == 4 * s) m_bg[i] = m_tgt[i];
                m_fade[i] = 3 - (m_k[i] - 4 * s) / s;
            end
            if (m_k[i] == 7 * s) begin
                m_trans[i] = 1'b0;
                m_busy[i]  = 0;
                m_dwell[i] = 0;
            end
        end else if (!a_in) begin
            m_dwell[i] = 0;
            if (s_in == m_prev[i] && s_in != m_bg[i]) model_start(i, s_in);
        end else if (m_dwell[i] == dw[i] - 1) begin
            m_dwell[i] = 0;
            model_start(i, (m_bg[i] + 1) % 4);
        end else begin
            m_dwell[i]++;
        end
        m_prev[i] = s_in;
        if (!h_in) m_anim[i] = (m_anim[i] + 1) % 1024;
    endfunction

    function automatic logic [14:0] model_pack(int i);
        return {2'(m_bg[i]), 2'(m_fade[i]), 10'(m_anim[i]), 1'(m_busy[i])};
    endfunction

    task automatic do_frame(int s_in, bit a_in, bit h_in, bit r_in, int gap);
        @(negedge clk);
        sel = 2'(s_in); auto_v = a_in; hold_v = h_in; reset = r_in; fs = 1'b1;
        if (r_in) begin
            model_reset();
        end else begin
            model_frame(0, s_in, a_in, h_in);
            model_frame(1, s_in, a_in, h_in);
            q0.push_back(model_pack(0));
            q1.push_back(model_pack(1));
        end
        @(negedge clk);
        fs = 1'b0; reset = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Monitor: every cycle the outputs must equal the last expected frame state.
    logic [14:0] last [2];
    initial begin
        last[0] = '0;
        last[1] = '0;
    end

    always @(posedge clk) begin
        bit          r_s, f_s;
        logic [14:0] exp_v;
        string       nm;
        r_s = reset;
        f_s = fs;
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_v = last[i];
            nm    = "stable";
            if (r_s) begin
                exp_v = '0;
                nm    = "reset";
            end else if (f_s) begin
                nm = "frame";
                if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                    total++; bad++;
                    $display("FAIL queue_empty dut%0d: frame seen with no expected entry", i);
                end else begin
                    exp_v = (i == 0) ? q0.pop_front() : q1.pop_front();
                end
            end
            last[i] = exp_v;
            total++;
            if (obs[i] !== exp_v) begin
                bad++;
                $display("FAIL %s dut%0d t=%0t: got bg=%0d fade=%0d anim=%0d busy=%0d, want bg=%0d fade=%0d anim=%0d busy=%0d",
                         nm, i, $time, obs[i][14:13], obs[i][12:11], obs[i][10:1], obs[i][0],
                         exp_v[14:13], exp_v[12:11], exp_v[10:1], exp_v[0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_r;
        bit a_r, h_r;
        reset = 1'b1; fs = 1'b0; sel = 2'd0; auto_v = 1'b0; hold_v = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset held across frame pulses
        repeat (3) do_frame(0, 0, 0, 1, 0);

        // Manual switch to blue
        repeat (18) do_frame(2, 0, 0, 0, 2);

        // One-frame glitch must not trigger
        do_frame(1, 0, 0, 0, 2);
        repeat (4) do_frame(2, 0, 0, 0, 2);

        // Retarget request during a fade is deferred to SHOW
        repeat (4) do_frame(0, 0, 0, 0, 1);
        repeat (40) do_frame(3, 0, 0, 0, 1);

        // Auto cycling, then reset mid-run
        repeat (70) do_frame(3, 1, 0, 0, 1);
        repeat (8) do_frame(3, 1, 0, 0, 1);
        do_frame(3, 1, 0, 1, 1);
        repeat (10) do_frame(3, 1, 0, 0, 1);

        // Randomised requests, mode toggles, holds and resets
        s_r = 0; a_r = 1'b0; h_r = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)  s_r = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) a_r = ~a_r;
            h_r = ($urandom_range(0, 3) == 0);
            do_frame(s_r, a_r, h_r, ($urandom_range(0, 63) == 0), $urandom_range(0, 3));
        end

        // Animation counter wrap, hold, and reset coincident with a frame
        do_frame(0, 0, 0, 1, 0);
        repeat (1030) do_frame(0, 0, 0, 0, 0);
        repeat (5) do_frame(0, 0, 1, 0, 1);
        do_frame(0, 0, 0, 1, 1);
        repeat (3) do_frame(0, 0, 0, 0, 1);

        repeat (3) @(negedge clk);
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d pending entries, want 0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
